// File: rtl/axi_lite_master_bridge.sv
// AXI4-Lite initiator: turns single-beat register commands into AXI4-Lite write or read
// transactions, one outstanding at a time, with a wait-state timeout for hung slaves.
module axi_lite_master_bridge #(
   parameter int REG_WIDTH      = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr,
   input  logic [REG_WIDTH-1:0]   cmd_wdata,
   input  logic [REG_WIDTH/8-1:0] cmd_wstrb,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [REG_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]             rsp_resp,
   output logic                   rsp_timeout,
   output logic [ADDR_WIDTH-1:0]  AWADDR,
   output logic                   AWVALID,
   input  logic                   AWREADY,
   output logic [REG_WIDTH-1:0]   WDATA,
   output logic [REG_WIDTH/8-1:0] WSTRB,
   output logic                   WVALID,
   input  logic                   WREADY,
   input  logic                   BVALID,
   output logic                   BREADY,
   input  logic [1:0]             BRESP,
   output logic [ADDR_WIDTH-1:0]  ARADDR,
   output logic                   ARVALID,
   input  logic                   ARREADY,
   input  logic                   RVALID,
   output logic                   RREADY,
   input  logic [REG_WIDTH-1:0]   RDATA,
   input  logic [1:0]             RRESP
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
   logic [REG_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic [REG_WIDTH-1:0]   rspRdata_q, rspRdata_d;
   logic [1:0]             rspResp_q, rspResp_d;
   logic                   rspTimeout_q, rspTimeout_d;
   logic                   awValid_q, awValid_d, wValid_q, wValid_d, arValid_q, arValid_d;
   logic                   bReady_q, bReady_d, rReady_q, rReady_d;
   logic                   cmdReady_q, cmdReady_d, rspValid_q, rspValid_d;
   logic                   awDone, wDone, waiting, expired;

   // Next state; an expired wait counter overrides whatever the bus did on that edge.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      rspRdata_d   = rspRdata_q;
      rspResp_d    = rspResp_q;
      rspTimeout_d = rspTimeout_q;
      awDone       = !awValid_q || AWREADY;
      wDone        = !wValid_q || WREADY;
      waiting      = (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA});
      expired      = waiting && (cnt_q == TMAX);
      if (expired) begin
         state_d      = RESP;
         rspResp_d    = 2'b10;
         rspTimeout_d = 1'b1;
         rspRdata_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd_valid && cmdReady_q) begin
                  addr_d       = cmd_addr;
                  wdata_d      = cmd_wdata;
                  wstrb_d      = cmd_wstrb;
                  rspTimeout_d = 1'b0;
                  state_d      = cmd_write ? WR_REQ : RD_REQ;
               end
            end
            WR_REQ: begin
               if (awDone && wDone) state_d = WR_RESP;
            end
            WR_RESP: begin
               if (BVALID && bReady_q) begin
                  rspResp_d  = BRESP;
                  rspRdata_d = '0;
                  state_d    = RESP;
               end
            end
            RD_REQ: begin
               if (ARREADY && arValid_q) state_d = RD_DATA;
            end
            RD_DATA: begin
               if (RVALID && rReady_q) begin
                  rspResp_d  = RRESP;
                  rspRdata_d = RDATA;
                  state_d    = RESP;
               end
            end
            RESP: begin
               if (rsp_ready && rspValid_q) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      cnt_d = (state_d != state_q) ? '0 : (waiting ? cnt_q + 1'b1 : cnt_q);

      // AW and W each retire on their own handshake while the pair stays in WR_REQ.
      awValid_d = 1'b0;
      wValid_d  = 1'b0;
      if (state_d == WR_REQ) begin
         awValid_d = (state_q == WR_REQ) ? (awValid_q && !AWREADY) : 1'b1;
         wValid_d  = (state_q == WR_REQ) ? (wValid_q && !WREADY) : 1'b1;
      end
      arValid_d  = (state_d == RD_REQ);
      bReady_d   = (state_d == WR_RESP);
      rReady_d   = (state_d == RD_DATA);
      rspValid_d = (state_d == RESP);
      cmdReady_d = (state_d == IDLE);
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         rspRdata_q   <= '0;
         rspResp_q    <= '0;
         rspTimeout_q <= 1'b0;
         awValid_q    <= 1'b0;
         wValid_q     <= 1'b0;
         arValid_q    <= 1'b0;
         bReady_q     <= 1'b0;
         rReady_q     <= 1'b0;
         cmdReady_q   <= 1'b0;
         rspValid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         rspRdata_q   <= rspRdata_d;
         rspResp_q    <= rspResp_d;
         rspTimeout_q <= rspTimeout_d;
         awValid_q    <= awValid_d;
         wValid_q     <= wValid_d;
         arValid_q    <= arValid_d;
         bReady_q     <= bReady_d;
         rReady_q     <= rReady_d;
         cmdReady_q   <= cmdReady_d;
         rspValid_q   <= rspValid_d;
      end
   end

   assign cmd_ready   = cmdReady_q;
   assign rsp_valid   = rspValid_q;
   assign rsp_rdata   = rspRdata_q;
   assign rsp_resp    = rspResp_q;
   assign rsp_timeout = rspTimeout_q;
   assign AWADDR      = addr_q;
   assign ARADDR      = addr_q;
   assign WDATA       = wdata_q;
   assign WSTRB       = wstrb_q;
   assign AWVALID     = awValid_q;
   assign WVALID      = wValid_q;
   assign ARVALID     = arValid_q;
   assign BREADY      = bReady_q;
   assign RREADY      = rReady_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: a configurable AXI4-Lite slave model drives the bus,
// expected responses are queued at command time and popped when rsp_valid appears.
module tb_axi_lite_master_bridge;

   localparam int TMO = 16;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        tmo;
   } rsp_t;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        cmd_ready, rsp_valid, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [3:0]  WSTRB;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY;
   logic        RVALID, RREADY;
   logic [1:0]  BRESP, RRESP;

   int   errors = 0;
   int   checks = 0;
   rsp_t expQ[$];

   // Slave configuration, written only by the test sequence.
   int          awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0;
   bit          awHang = 0, wHang = 0, bHang = 0, rHang = 0;
   logic [1:0]  bRespCfg = 2'b00, rRespCfg = 2'b00;
   logic [31:0] rDataCfg = '0;

   // Slave state and activity counters, written only by the slave process.
   int awCnt, wCnt, bCnt, arCnt, rCnt;
   bit awDone, wDone, arDone, bFire, rFire;
   int awvCycles = 0, wvCycles = 0, arvCycles = 0, rrdyCycles = 0, bHs = 0;

   axi_lite_master_bridge #(
      .REG_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
   );

   initial forever #5 ACLK = ~ACLK;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog");
   end

   // Slave model: updates at the falling edge, so a handshake decided here fires at the next rising edge.
   initial begin
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
      awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
      awDone = 0; wDone = 0; arDone = 0; bFire = 0; rFire = 0;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
            awDone = 0; wDone = 0; arDone = 0; bFire = 0; rFire = 0;
         end else begin
            if (bFire) begin BVALID = 0; bFire = 0; end
            if (rFire) begin RVALID = 0; rFire = 0; end
            if (!AWVALID && !WVALID && !BREADY) begin awDone = 0; wDone = 0; bCnt = 0; BVALID = 0; end
            if (!ARVALID && !RREADY) begin arDone = 0; rCnt = 0; RVALID = 0; end
            if (awDone && wDone && !BVALID && !bHang) begin
               if (bCnt >= bDelay) begin
                  BVALID = 1; BRESP = bRespCfg; awDone = 0; wDone = 0; bCnt = 0;
               end else bCnt++;
            end
            if (arDone && !RVALID && !rHang) begin
               if (rCnt >= rDelay) begin
                  RVALID = 1; RDATA = rDataCfg; RRESP = rRespCfg; arDone = 0; rCnt = 0;
               end else rCnt++;
            end
            if (AWVALID) begin AWREADY = !awHang && (awCnt >= awDelay); awCnt++; end
            else begin AWREADY = 0; awCnt = 0; end
            if (WVALID) begin WREADY = !wHang && (wCnt >= wDelay); wCnt++; end
            else begin WREADY = 0; wCnt = 0; end
            if (ARVALID) begin ARREADY = (arCnt >= arDelay); arCnt++; end
            else begin ARREADY = 0; arCnt = 0; end
            if (AWVALID && AWREADY) awDone = 1;
            if (WVALID && WREADY) wDone = 1;
            if (ARVALID && ARREADY) arDone = 1;
            bFire = BVALID && BREADY;
            rFire = RVALID && RREADY;
            if (bFire) bHs++;
            if (AWVALID) awvCycles++;
            if (WVALID) wvCycles++;
            if (ARVALID) arvCycles++;
            if (RREADY) rrdyCycles++;
         end
      end
   end

   // Called at a falling edge; returns at the first falling edge after the accepting rising edge.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, output bit accepted);
      int n;
      cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      cmd_valid = 1'b1;
      accepted = 0;
      n = 0;
      while (!accepted && n < 50) begin
         accepted = cmd_ready;
         @(negedge ACLK);
         n++;
      end
      cmd_valid = 1'b0;
   endtask

   // Pops the scoreboard when a response appears; lat counts falling edges since accept.
   task automatic checkOutput(input int hold, output int lat);
      rsp_t e;
      lat = 1;
      while (!rsp_valid && lat < 100) begin
         @(negedge ACLK);
         lat++;
      end
      checks++;
      if (!rsp_valid) begin
         errors++;
         $display("[TB] FAIL rsp_wait: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, lat);
      end else if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL rsp_unexpected: response rdata=%h with empty scoreboard", rsp_rdata);
      end else begin
         e = expQ.pop_front();
         repeat (hold) @(negedge ACLK);
         checks++;
         if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rsp_hold: rsp_valid=%0b, required 1", rsp_valid);
         end
         checks++;
         if (rsp_rdata !== e.rdata) begin
            errors++;
            $display("[TB] FAIL rsp_rdata: got %h, expected %h", rsp_rdata, e.rdata);
         end
         checks++;
         if (rsp_resp !== e.resp) begin
            errors++;
            $display("[TB] FAIL rsp_resp: got %b, expected %b", rsp_resp, e.resp);
         end
         checks++;
         if (rsp_timeout !== e.tmo) begin
            errors++;
            $display("[TB] FAIL rsp_timeout: got %b, expected %b", rsp_timeout, e.tmo);
         end
         rsp_ready = 1'b1;
         @(negedge ACLK);
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 7'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b, expected 0000000",
                  {cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY});
      end
      checks++;
      if ({AWADDR, WDATA, WSTRB, rsp_rdata, rsp_resp, rsp_timeout} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data: AWADDR=%h WDATA=%h rdata=%h resp=%b, expected all 0",
                  AWADDR, WDATA, rsp_rdata, rsp_resp);
      end
      @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release: cmd_ready=%b, expected 1", cmd_ready);
      end
   endtask

   task automatic test_write_zero_wait();
      bit acc;
      int lat;
      expQ.push_back('{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
      applyStimulus(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, acc);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("[TB] FAIL wr0_accept: got %b, expected 1", acc); end
      checks++;
      if ({AWVALID, WVALID, AWADDR, WDATA, WSTRB} !== {2'b11, 32'h4, 32'hDEADBEEF, 4'hF}) begin
         errors++;
         $display("[TB] FAIL wr0_bus: AWVALID=%b WVALID=%b AWADDR=%h WDATA=%h WSTRB=%h, expected 1 1 4 deadbeef f",
                  AWVALID, WVALID, AWADDR, WDATA, WSTRB);
      end
      checkOutput(0, lat);
      checks++;
      if (lat !== 3) begin errors++; $display("[TB] FAIL wr0_latency: got %0d, expected 3", lat); end
   endtask

   task automatic test_write_aw_delay();
      bit acc;
      int lat, aw0, w0, b0;
      awDelay = 6;
      aw0 = awvCycles; w0 = wvCycles; b0 = bHs;
      expQ.push_back('{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
      applyStimulus(1'b1, 32'h8, 32'hCAFEBABE, 4'hF, acc);
      checkOutput(0, lat);
      awDelay = 0;
      checks++;
      if (awvCycles - aw0 !== 7) begin
         errors++; $display("[TB] FAIL awdly_awvalid: high %0d cycles, expected 7", awvCycles - aw0);
      end
      checks++;
      if (wvCycles - w0 !== 1) begin
         errors++; $display("[TB] FAIL awdly_wvalid: high %0d cycles, expected 1", wvCycles - w0);
      end
      checks++;
      if (bHs - b0 !== 1) begin
         errors++; $display("[TB] FAIL awdly_bhs: %0d B handshakes, expected 1", bHs - b0);
      end
   endtask

   task automatic test_write_bresp_err();
      bit acc;
      int lat;
      bRespCfg = 2'b11;
      bDelay = 2;
      expQ.push_back('{rdata: 32'h0, resp: 2'b11, tmo: 1'b0});
      applyStimulus(1'b1, 32'h10, 32'h0BAD0BAD, 4'h3, acc);
      checkOutput(3, lat);
      bRespCfg = 2'b00;
      bDelay = 0;
   endtask

   task automatic test_read_wait();
      bit acc;
      int lat, ar0, rr0;
      rDelay = 5;
      rDataCfg = 32'h12345678;
      ar0 = arvCycles; rr0 = rrdyCycles;
      expQ.push_back('{rdata: 32'h12345678, resp: 2'b00, tmo: 1'b0});
      applyStimulus(1'b0, 32'h4, 32'hFFFFFFFF, 4'h0, acc);
      checks++;
      if ({ARVALID, ARADDR} !== {1'b1, 32'h4}) begin
         errors++; $display("[TB] FAIL rd_bus: ARVALID=%b ARADDR=%h, expected 1 00000004", ARVALID, ARADDR);
      end
      checkOutput(0, lat);
      rDelay = 0;
      checks++;
      if (arvCycles - ar0 !== 1) begin
         errors++; $display("[TB] FAIL rd_arvalid: high %0d cycles, expected 1", arvCycles - ar0);
      end
      checks++;
      if (rrdyCycles - rr0 !== 6) begin
         errors++; $display("[TB] FAIL rd_rready: high %0d cycles, expected 6", rrdyCycles - rr0);
      end
      checks++;
      if (lat !== 8) begin errors++; $display("[TB] FAIL rd_latency: got %0d, expected 8", lat); end
   endtask

   task automatic test_timeout();
      bit acc;
      int lat, aw0, w0, b0;
      awHang = 1; wHang = 1;
      aw0 = awvCycles; w0 = wvCycles; b0 = bHs;
      expQ.push_back('{rdata: 32'h0, resp: 2'b10, tmo: 1'b1});
      applyStimulus(1'b1, 32'h20, 32'h55AA55AA, 4'hF, acc);
      checkOutput(0, lat);
      awHang = 0; wHang = 0;
      checks++;
      if (lat !== TMO + 1) begin
         errors++; $display("[TB] FAIL tmo_latency: got %0d, expected %0d", lat, TMO + 1);
      end
      checks++;
      if ((awvCycles - aw0 !== TMO) || (wvCycles - w0 !== TMO)) begin
         errors++;
         $display("[TB] FAIL tmo_valid: AWVALID %0d WVALID %0d cycles, expected %0d each",
                  awvCycles - aw0, wvCycles - w0, TMO);
      end
      checks++;
      if (bHs - b0 !== 0) begin errors++; $display("[TB] FAIL tmo_bhs: got %0d, expected 0", bHs - b0); end
      expQ.push_back('{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
      applyStimulus(1'b1, 32'h24, 32'h01020304, 4'h1, acc);
      checks++;
      if ({acc, rsp_timeout} !== 2'b10) begin
         errors++; $display("[TB] FAIL tmo_clear: accepted=%b rsp_timeout=%b, expected 1 0", acc, rsp_timeout);
      end
      checkOutput(0, lat);
   endtask

   task automatic test_back_to_back();
      bit acc;
      int lat;
      rDataCfg = 32'hA5A5A5A5;
      rRespCfg = 2'b01;
      expQ.push_back('{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
      applyStimulus(1'b1, 32'hC, 32'h11111111, 4'hF, acc);
      checkOutput(0, lat);
      checks++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
         errors++; $display("[TB] FAIL b2b_ready: cmd_ready=%b rsp_valid=%b, expected 1 0", cmd_ready, rsp_valid);
      end
      expQ.push_back('{rdata: 32'hA5A5A5A5, resp: 2'b01, tmo: 1'b0});
      applyStimulus(1'b0, 32'hC, 32'h0, 4'h0, acc);
      checkOutput(0, lat);
      checks++;
      if (lat !== 3) begin errors++; $display("[TB] FAIL b2b_rd_latency: got %0d, expected 3", lat); end
      rRespCfg = 2'b00;
   endtask

   task automatic test_reset_mid_read();
      bit acc, sawRsp;
      int n;
      rHang = 1;
      applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, acc);
      n = 0;
      while (!RREADY && n < 10) begin @(negedge ACLK); n++; end
      checks++;
      if (RREADY !== 1'b1) begin errors++; $display("[TB] FAIL rst_rd_reach: RREADY=%b, expected 1", RREADY); end
      #2 ARESET = 1'b1;
      #1;
      checks++;
      if ({cmd_ready, rsp_valid, ARVALID, RREADY, ARADDR} !== '0) begin
         errors++;
         $display("[TB] FAIL rst_async: cmd_ready=%b rsp_valid=%b ARVALID=%b RREADY=%b ARADDR=%h, expected all 0",
                  cmd_ready, rsp_valid, ARVALID, RREADY, ARADDR);
      end
      @(negedge ACLK);
      ARESET = 1'b0;
      rHang = 0;
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_hold: cmd_ready=%b, expected 0", cmd_ready); end
      @(negedge ACLK);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: cmd_ready=%b, expected 1", cmd_ready); end
      sawRsp = 0;
      repeat (20) begin
         if (rsp_valid) sawRsp = 1;
         @(negedge ACLK);
      end
      checks++;
      if (sawRsp !== 1'b0) begin errors++; $display("[TB] FAIL rst_norsp: rsp_valid seen=%b, expected 0", sawRsp); end
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_write_aw_delay();
      test_write_bresp_err();
      test_read_wait();
      test_timeout();
      test_back_to_back();
      test_reset_mid_read();
      checks++;
      if (expQ.size() !== 0) begin
         errors++; $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_master_bridge.md
# axi_lite_master_bridge

AXI4-Lite initiator that turns single-beat register commands from an internal requester (DMA control sequencer, test harness) into AXI4-Lite write or read transactions. It drives the master side of the bus that `axi_lite_reg_interface` responds on. One outstanding transaction at a time. A timeout recovers from a hung slave.

## Interface
Parameters:
- REG_WIDTH, 32, data width; multiple of 8
- ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 256, cycles allowed in any bus-wait state before abort; ≥2

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESET  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when both valid and ready are high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  REG_WIDTH  write data
- cmd_wstrb  in  REG_WIDTH/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  REG_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP as returned; 2'b10 on timeout
- rsp_timeout  out  1  transaction aborted by timeout
- AWADDR, AWVALID out; AWREADY in: write address channel
- WDATA, WSTRB, WVALID out; WREADY in: write data channel
- BVALID in; BREADY out; BRESP in (2): write response channel
- ARADDR, ARVALID out; ARREADY in: read address channel
- RVALID in; RREADY out; RDATA in (REG_WIDTH); RRESP in (2): read data channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- IDLE: cmd_ready=1. On accept, latch addr/wdata/wstrb into AWADDR/ARADDR/WDATA/WSTRB. Go to WR_REQ (write) or RD_REQ (read).
- WR_REQ: AWVALID and WVALID both assert on entry. Each drops independently the cycle after its own handshake (VALID&READY at an edge). Move to WR_RESP when both handshakes have completed; they may complete on the same edge or in either order.
- WR_RESP: BREADY=1. On BVALID&BREADY: capture BRESP, set rsp_rdata=0, go to RESP.
- RD_REQ: ARVALID=1 until ARREADY handshake, then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID&RREADY: capture RDATA/RRESP, go to RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready. Return to IDLE on the handshake edge. No timeout applies in this state.
- Address and data outputs hold their latched values until the next accept.
- Timeout: a counter clears on every state change. In WR_REQ, WR_RESP, RD_REQ and RD_DATA it increments each cycle. When it reaches TIMEOUT_CYCLES-1, the next edge:
  - drops all VALID/READY outputs
  - sets rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0
  - enters RESP
- rsp_timeout is cleared on the next command accept.
- Reset (async, any state): state=IDLE, all VALID/READY outputs 0, rsp_* 0, addr/data outputs 0, counter 0. An in-flight transaction is dropped with no response.

## Timing
- Accept at edge N: AWVALID/WVALID or ARVALID high from N+1. No combinational path from cmd_* to the bus.
- Write with a zero-wait slave:
  - AW/W handshake at edge N+1
  - BREADY high from N+2; BVALID at N+2 gives a handshake at edge N+2
  - rsp_valid high from N+3
  - cmd_ready high again after the rsp handshake: minimum 4 cycles per write.
- Read with a zero-wait slave: AR handshake at N+1, R handshake at N+2, rsp_valid from N+3.
- BREADY/RREADY are registered and high for the whole WR_RESP/RD_DATA state. A VALID that arrives earlier is held by the slave, per AXI.
- Reset values of all outputs: 0.

## Test plan
- Write 0x4 = 0xDEADBEEF, wstrb 0xF, zero-wait slave → AWADDR=0x4, WDATA=0xDEADBEEF on the bus; rsp_valid at accept+3; rsp_resp=00; rsp_rdata=0.
- Write 0x8 = 0xCAFEBABE with WREADY at +1 and AWREADY delayed 7 cycles → WVALID drops after its own handshake, AWVALID holds 7 cycles; exactly one B handshake; rsp_resp=00.
- Write 0x10 where the slave returns BRESP=2'b11 → rsp_resp=11, rsp_timeout=0.
- Read 0x4 where the slave returns RDATA=0x12345678, RRESP=00 after 5 wait cycles → rsp_rdata=0x12345678, rsp_resp=00; ARVALID high 1 cycle; RREADY high until the R handshake.
- TIMEOUT_CYCLES=16, AWREADY held low → AWVALID and WVALID drop after 16 cycles in WR_REQ; rsp_resp=10, rsp_timeout=1; next command accepted normally and rsp_timeout clears.
- ARESET pulsed mid-read while in RD_DATA, with rsp_ready held low on the prior response → all outputs 0 immediately (asynchronous); cmd_ready=1 on the first edge after reset deasserts; no rsp_valid for the aborted read.
